mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all ports.
REQ-002 Parameter DATA_W, default 32: data width of all ports.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_req  input  1  fetch-side read request; held until i_ready.
REQ-006 i_addr  input  ADDR_W  fetch address; stable while i_req is high.
REQ-007 i_ready  output  1  one-cycle pulse; i_rdata is valid in that cycle.
REQ-008 i_rdata  output  DATA_W  fetch read data, registered.
REQ-009 d_req  input  1  data-side request; held until d_ready.
REQ-010 d_we  input  1  1 = write, 0 = read.
REQ-011 d_addr  input  ADDR_W  data address.
REQ-012 d_wdata  input  DATA_W  write data.
REQ-013 d_ready  output  1  one-cycle completion pulse.
REQ-014 d_rdata  output  DATA_W  data read data, registered.
REQ-015 mem_req  output  1  memory request; held until mem_ack.
REQ-016 mem_we  output  1  memory write enable.
REQ-017 mem_addr  output  ADDR_W  memory address.
REQ-018 mem_wdata  output  DATA_W  memory write data.
REQ-019 mem_ack  input  1  one-cycle memory completion; mem_rdata valid with it.
REQ-020 mem_rdata  input  DATA_W  memory read data.
REQ-021 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, MEM and RESP.
REQ-023 In IDLE with any request high, the block SHALL select one owner and latch its address, write enable and write data into internal registers, then move to MEM.
REQ-024 If only one side requests, that side SHALL be granted; if both request in the same cycle, the side not served last SHALL be granted, using the last_owner register.
REQ-025 In MEM: mem_req=1; mem_addr, mem_we and mem_wdata SHALL be driven from the latched registers and held stable until mem_ack.
REQ-026 A fetch grant SHALL drive mem_we=0.
REQ-027 On mem_ack in MEM, mem_rdata SHALL be captured into the owner's rdata register, and the FSM SHALL move to RESP.
REQ-028 In RESP, the owner's ready SHALL pulse for exactly one cycle, last_owner SHALL update to that owner, and the FSM SHALL return to IDLE.
REQ-029 Request inputs SHALL NOT be sampled in MEM or RESP. The earliest next grant is the IDLE cycle after RESP.
REQ-030 Latency: request seen in IDLE at cycle 0; mem_req high from cycle 1; mem_ack at cycle k (k>=1); ready at cycle k+1.
REQ-031 Each port's rdata SHALL hold its value until that port's next completed transaction; a d-side write also updates d_rdata with mem_rdata.
REQ-032 mem_ack arriving outside MEM SHALL be ignored.
REQ-033 Deasserting a request after grant SHALL NOT cancel the transaction; the ready pulse still occurs.
REQ-034 Under continuous requests from both sides, grants SHALL strictly alternate: no side waits more than one transaction.
REQ-035 Ready outputs SHALL never both be high, and only the current owner's ready may pulse.

Reset
REQ-036 With rst_n=0 at a clock edge, the block SHALL set: state=IDLE; mem_req, mem_we, i_ready, d_ready and busy to 0; i_rdata, d_rdata, mem_addr and mem_wdata to 0; last_owner=fetch, so data wins the first tie.
REQ-037 Reset in MEM or RESP SHALL abort the transaction with no ready pulse; mem_req SHALL drop at that edge, and a later mem_ack SHALL be ignored.

Verification
REQ-038 Single fetch: i_req, i_addr=0x100; mem_ack 3 cycles after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x100 and mem_we=0; i_ready pulses once the cycle after ack; i_rdata=0xDEADBEEF.
REQ-039 Simultaneous first requests: i_req and d_req both high after reset -> data granted first, fetch granted next IDLE; exactly one i_ready and one d_ready.
REQ-040 Continuous contention, 6 transactions -> owner order D,I,D,I,D,I.
REQ-041 Data write: d_we=1, d_addr=0x2000, d_wdata=0x12345678 -> mem_we=1 with those values held until ack; d_ready pulses once.
REQ-042 Reset mid-MEM: rst_n low for 1 cycle during MEM, then mem_ack -> no ready pulse, busy=0, state IDLE.
REQ-043 Spurious ack: mem_ack pulsed in IDLE -> no state change, no ready pulse, rdata unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a fetch port and a data port share one memory bus.
// Ties are broken against the port that was served last.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEM,
      S_RESP
   } state_e;

   state_e            state_q, state_d;
   // owner/last_owner encoding: 1 = data port, 0 = fetch port
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic              grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         owner_q   <= 1'b0;
         last_q    <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      grant_d   = d_req && (!i_req || !last_q);
      unique case (state_q)
         S_IDLE: begin
            if (i_req || d_req) begin
               owner_d = grant_d;
               addr_d  = grant_d ? d_addr : i_addr;
               we_d    = grant_d ? d_we : 1'b0;
               wdata_d = grant_d ? d_wdata : '0;
               state_d = S_MEM;
            end
         end
         S_MEM: begin
            if (mem_ack) begin
               if (owner_q) begin
                  d_rdata_d = mem_rdata;
               end else begin
                  i_rdata_d = mem_rdata;
               end
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            last_d  = owner_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mem_req   = (state_q == S_MEM);
   assign mem_we    = mem_req && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign i_ready   = (state_q == S_RESP) && !owner_q;
   assign d_ready   = (state_q == S_RESP) && owner_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = (state_q != S_IDLE);

endmodule
